// File: rtl/led_pkg.sv
// Shared constants for the rotating-LED step controller and its shift-register top level.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package led_pkg;

    // Speed index selects one of four step periods.
    localparam int SPEED_W = 2;
    typedef logic [SPEED_W-1:0] speed_t;

    // Step generator states.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    // Board defaults: 1 s, 0.5 s, 0.25 s and 0.125 s per step at 100 MHz.
    localparam int          DEF_CNT_WIDTH       = 27;
    localparam int unsigned DEF_PERIOD0         = 100_000_000;
    localparam int unsigned DEF_PERIOD1         = 50_000_000;
    localparam int unsigned DEF_PERIOD2         = 25_000_000;
    localparam int unsigned DEF_PERIOD3         = 12_500_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/led_step_ctrl_btn_debounce.sv
// Synchronises and debounces one raw push-button; emits a one-cycle pulse on each accepted press.
// Latency: raw level held from edge k gives o_press high after edge k+2+DEBOUNCE_CYCLES.
// Backpressure: none; o_press is a pulse that the consumer must take in the cycle it is high.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    // Two-flop synchroniser, then accept a new level only after it has persisted long enough.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_btn};
            press_q <= 1'b0;
            if (sync_q[1] != stable_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                    stable_q <= sync_q[1];
                    cnt_q    <= '0;
                    // Only a rising accepted level counts as a press.
                    press_q  <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign o_level = stable_q;
    assign o_press = press_q;

endmodule

// File: rtl/led_step_ctrl.sv
// Generates the one-cycle step pulse for the rotating-LED shift stage, with run/pause and 4 step rates.
// Latency: o_valid every PERIOD[o_speed] cycles in RUN; state/speed update one edge after a press pulse.
// Backpressure: none; the shift stage accepts every o_valid pulse unconditionally.
module led_step_ctrl
    import led_pkg::*;
#(
    parameter int          CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int unsigned PERIOD0         = DEF_PERIOD0,
    parameter int unsigned PERIOD1         = DEF_PERIOD1,
    parameter int unsigned PERIOD2         = DEF_PERIOD2,
    parameter int unsigned PERIOD3         = DEF_PERIOD3,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_btn_run,
    input  logic               i_btn_speed,
    output logic               o_valid,
    output logic               o_running,
    output logic [SPEED_W-1:0] o_speed
);

    // Terminal counts; a period of exactly 2^CNT_WIDTH still fits once reduced by one.
    localparam logic [CNT_WIDTH-1:0] TC0 = CNT_WIDTH'(PERIOD0 - 1);
    localparam logic [CNT_WIDTH-1:0] TC1 = CNT_WIDTH'(PERIOD1 - 1);
    localparam logic [CNT_WIDTH-1:0] TC2 = CNT_WIDTH'(PERIOD2 - 1);
    localparam logic [CNT_WIDTH-1:0] TC3 = CNT_WIDTH'(PERIOD3 - 1);

    logic run_press;
    logic speed_press;
    logic unused_run_level;
    logic unused_speed_level;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
        .clock   (clock),
        .i_reset (i_reset),
        .i_btn   (i_btn_run),
        .o_level (unused_run_level),
        .o_press (run_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed_btn (
        .clock   (clock),
        .i_reset (i_reset),
        .i_btn   (i_btn_speed),
        .o_level (unused_speed_level),
        .o_press (speed_press)
    );

    state_t                 state_q, state_d;
    speed_t                 speed_q, speed_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   tc_val;

    // Select the terminal count for the current speed.
    always_comb begin
        tc_val = TC0;
        case (speed_q)
            2'd0:    tc_val = TC0;
            2'd1:    tc_val = TC1;
            2'd2:    tc_val = TC2;
            default: tc_val = TC3;
        endcase
    end

    // Register state, speed, period counter and the step pulse.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state_q <= ST_RUN;
            speed_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Next state: count in RUN, hold in PAUSE; any press restarts the period and suppresses the step.
    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (state_q == ST_RUN) begin
            if (cnt_q == tc_val) begin
                cnt_d   = '0;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end else begin
            cnt_d = '0;
        end
        if (run_press) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
            cnt_d   = '0;
            valid_d = 1'b0;
        end
        if (speed_press) begin
            speed_d = speed_q + SPEED_W'(1);
            cnt_d   = '0;
            valid_d = 1'b0;
        end
    end

    assign o_valid   = valid_q;
    assign o_running = (state_q == ST_RUN);
    assign o_speed   = speed_q;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Randomised bench for led_step_ctrl with an edge-indexed reference model and a decoupled scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_led_step_ctrl;

    localparam int DEB = 3;
    localparam int PER [4] = '{4, 8, 16, 32};

    logic       clock;
    logic       i_reset;
    logic       i_btn_run;
    logic       i_btn_speed;
    logic       o_valid;
    logic       o_running;
    logic [1:0] o_speed;

    led_step_ctrl #(
        .CNT_WIDTH       (5),
        .PERIOD0         (4),
        .PERIOD1         (8),
        .PERIOD2         (16),
        .PERIOD3         (32),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_btn_run   (i_btn_run),
        .i_btn_speed (i_btn_speed),
        .o_valid     (o_valid),
        .o_running   (o_running),
        .o_speed     (o_speed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int unsigned e;
        bit          run;
        bit [1:0]    spd;
    } exp_t;

    exp_t        st_q[$];
    int unsigned pulse_q[$];
    int unsigned edge_n = 0;
    int          n_vec  = 0;
    int          n_miss = 0;

    // Reference model state, expressed in edges since the last period restart.
    bit          m_running;
    int          m_speed;
    int unsigned m_start;
    bit          m_stable [2];
    int          m_streak [2];
    bit          m_pend   [2];
    bit          dl_run[$];
    bit          dl_spd[$];

    // A level is accepted once the synchronised input has differed for DEB+1 consecutive edges.
    task automatic deb(input int b, input bit s);
        if (s != m_stable[b]) begin
            m_streak[b]++;
            if (m_streak[b] == DEB + 1) begin
                m_stable[b] = s;
                m_streak[b] = 0;
                if (s) m_pend[b] = 1'b1;
            end
        end else begin
            m_streak[b] = 0;
        end
    endtask

    // Advance the model by one rising edge using the inputs sampled at that edge.
    task automatic model_step();
        bit   rp, sp, s0, s1;
        exp_t x;
        if (!i_reset) begin
            m_running = 1'b1;
            m_speed   = 0;
            m_start   = edge_n;
            for (int b = 0; b < 2; b++) begin
                m_stable[b] = 1'b0;
                m_streak[b] = 0;
                m_pend[b]   = 1'b0;
            end
            dl_run = '{1'b0, 1'b0};
            dl_spd = '{1'b0, 1'b0};
        end else begin
            rp = m_pend[0];
            sp = m_pend[1];
            m_pend[0] = 1'b0;
            m_pend[1] = 1'b0;
            s0 = dl_run.pop_front();
            dl_run.push_back(i_btn_run);
            s1 = dl_spd.pop_front();
            dl_spd.push_back(i_btn_speed);
            deb(0, s0);
            deb(1, s1);
            if (rp || sp) begin
                if (rp) m_running = !m_running;
                if (sp) m_speed = (m_speed + 1) % 4;
                m_start = edge_n;
            end else if (m_running && ((edge_n - m_start) % PER[m_speed]) == 0) begin
                pulse_q.push_back(edge_n);
            end
        end
        x.e   = edge_n;
        x.run = m_running;
        x.spd = 2'(m_speed);
        st_q.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int exp_v, input int unsigned e);
        n_vec++;
        if (act != exp_v) begin
            n_miss++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e, act, exp_v);
        end
    endtask

    // Monitor: pop the expectation for the most recent edge and compare against outputs.
    exp_t mon_x;
    bit   mon_ev;
    always @(negedge clock) begin
        if (st_q.size() > 0) begin
            mon_x  = st_q.pop_front();
            mon_ev = 1'b0;
            if (pulse_q.size() > 0 && pulse_q[0] == mon_x.e) begin
                mon_ev = 1'b1;
                void'(pulse_q.pop_front());
            end
            check("o_valid",   int'(o_valid),   int'(mon_ev),    mon_x.e);
            check("o_running", int'(o_running), int'(mon_x.run), mon_x.e);
            check("o_speed",   int'(o_speed),   int'(mon_x.spd), mon_x.e);
        end
    end

    task automatic cyc(input logic r, input logic br, input logic bs);
        @(negedge clock);
        i_reset     = r;
        i_btn_run   = br;
        i_btn_speed = bs;
        @(posedge clock);
        edge_n++;
        model_step();
    endtask

    task automatic hold(input int n, input logic br, input logic bs);
        for (int i = 0; i < n; i++) cyc(1'b1, br, bs);
    endtask

    int unsigned len;
    bit          rb, sb;

    initial begin
        i_reset     = 1'b0;
        i_btn_run   = 1'b0;
        i_btn_speed = 1'b0;

        // Reset, then free-running steps at speed 0.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
        hold(20, 1'b0, 1'b0);

        // Four speed presses cycle 1, 2, 3, 0; long idle to see several periods each.
        for (int i = 0; i < 4; i++) begin
            hold(10, 1'b0, 1'b1);
            hold(80, 1'b0, 1'b0);
        end

        // Pause, stay quiet, resume.
        hold(10, 1'b1, 1'b0);
        hold(50, 1'b0, 1'b0);
        hold(10, 1'b1, 1'b0);
        hold(20, 1'b0, 1'b0);

        // Bounce: 2-high/2-low chatter, then a single-cycle glitch.
        for (int i = 0; i < 5; i++) begin
            hold(2, 1'b1, 1'b0);
            hold(2, 1'b0, 1'b0);
        end
        hold(20, 1'b0, 1'b0);
        hold(1, 1'b1, 1'b0);
        hold(12, 1'b0, 1'b0);

        // Run presses landing at random phases of the period, including the terminal count.
        for (int i = 0; i < 16; i++) begin
            len = $urandom_range(0, 7);
            hold(int'(len), 1'b0, 1'b0);
            hold(6, 1'b1, 1'b0);
            hold(3, 1'b0, 1'b0);
        end

        // Both buttons pressed together.
        for (int i = 0; i < 2; i++) begin
            hold(6, 1'b1, 1'b1);
            hold(40, 1'b0, 1'b0);
        end

        // Random button activity with random hold lengths.
        for (int i = 0; i < 60; i++) begin
            len = $urandom_range(1, 12);
            rb  = 1'($urandom_range(0, 1));
            sb  = 1'($urandom_range(0, 1));
            hold(int'(len), rb, sb);
        end
        hold(40, 1'b0, 1'b0);

        // Reset mid-operation at speed 2 in PAUSE with the run button held through release.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
        hold(5, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            hold(8, 1'b0, 1'b1);
            hold(6, 1'b0, 1'b0);
        end
        hold(8, 1'b1, 1'b0);
        hold(13, 1'b0, 1'b0);
        hold(3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
        hold(10, 1'b1, 1'b0);
        hold(20, 1'b0, 1'b0);
        hold(10, 1'b1, 1'b0);
        hold(40, 1'b0, 1'b0);

        // Let the monitor consume the last edge, then flag anything it never saw.
        @(negedge clock);
        #1;
        while (pulse_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL o_valid missing: expected pulse at edge %0d never observed", pulse_q[0]);
            void'(pulse_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
